// File: rtl/rf68000_mmu_loader_if.sv
// Wishbone-style config bus between the MMU map loader (master) and the MMU s_* port (slave).
interface rf68000_mmu_loader_if;
    logic        cs;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [7:0]  asid;
    logic [31:0] adr;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;

    modport master (
        output cs, cyc, stb, we, asid, adr, dat_o,
        input  dat_i, ack
    );

    modport slave (
        input  cs, cyc, stb, we, asid, adr, dat_o,
        output dat_i, ack
    );
endinterface

// File: rtl/rf68000_mmu_loader.sv
// Programs a run of consecutive rf68000 MMU page-map entries for one ASID over the config bus.
// Optional read-back verify of every entry is built when MMU_LOADER_VERIFY_EN is defined.
module rf68000_mmu_loader #(
    parameter logic [31:0] CFG_BASE  = 32'hFDC00000,
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [7:0]            asid_i,
    input  logic [8:0]            first_pg_i,
    input  logic [9:0]            count_i,
    input  logic [15:0]           base_ppn_i,
    input  logic [1:0]            wx_i,
    rf68000_mmu_loader_if.master  m,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [8:0]            err_pg_o
);

    localparam int unsigned   ToW    = $clog2(TO_CYCLES + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TO_CYCLES - 1);

`ifdef MMU_LOADER_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StWr, StWgap, StRd, StRgap, StFin} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWr, StWgap, StFin} state_e;
`endif

    state_e         state_q, state_d;
    logic [7:0]     asid_q, asid_d;
    logic [8:0]     page_q, page_d;
    logic [15:0]    ppn_q, ppn_d;
    logic [1:0]     wx_q, wx_d;
    logic [9:0]     rem_q, rem_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [8:0]     err_pg_q, err_pg_d;
    logic           in_bus;
    logic           next_page;
`ifdef MMU_LOADER_VERIFY_EN
    logic [17:0]    rdata_q, rdata_d;
    assign in_bus = (state_q == StWr) || (state_q == StRd);
`else
    assign in_bus = (state_q == StWr);
`endif

    always_comb begin
        state_d   = state_q;
        asid_d    = asid_q;
        page_d    = page_q;
        ppn_d     = ppn_q;
        wx_d      = wx_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_pg_d  = err_pg_q;
        next_page = 1'b0;
        // Free-running only while a bus cycle is open, so it restarts on every WR/RD entry.
        to_cnt_d  = in_bus ? to_cnt_q + 1'b1 : '0;
`ifdef MMU_LOADER_VERIFY_EN
        rdata_d   = rdata_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    asid_d   = asid_i;
                    page_d   = first_pg_i;
                    ppn_d    = base_ppn_i;
                    wx_d     = wx_i;
                    rem_d    = count_i;
                    err_d    = 1'b0;
                    err_pg_d = '0;
                    busy_d   = 1'b1;
                    state_d  = (count_i == '0) ? StFin : StWr;
                end
            end
            StWr: begin
                if (m.ack) begin
                    state_d = StWgap;
                end else if (to_cnt_q == ToLast) begin
                    err_d    = 1'b1;
                    err_pg_d = page_q;
                    state_d  = StFin;
                end
            end
            StWgap: begin
`ifdef MMU_LOADER_VERIFY_EN
                state_d = StRd;
`else
                next_page = 1'b1;
`endif
            end
`ifdef MMU_LOADER_VERIFY_EN
            StRd: begin
                if (m.ack) begin
                    rdata_d = m.dat_i[17:0];
                    state_d = StRgap;
                end else if (to_cnt_q == ToLast) begin
                    err_d    = 1'b1;
                    err_pg_d = page_q;
                    state_d  = StFin;
                end
            end
            StRgap: begin
                if (rdata_q != {wx_q, ppn_q}) begin
                    err_d    = 1'b1;
                    err_pg_d = page_q;
                    state_d  = StFin;
                end else begin
                    next_page = 1'b1;
                end
            end
`endif
            StFin: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Page and ppn wrap naturally at their register widths.
        if (next_page) begin
            page_d  = page_q + 1'b1;
            ppn_d   = ppn_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = (rem_q == 10'd1) ? StFin : StWr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            asid_q   <= '0;
            page_q   <= '0;
            ppn_q    <= '0;
            wx_q     <= '0;
            rem_q    <= '0;
            to_cnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            err_pg_q <= '0;
`ifdef MMU_LOADER_VERIFY_EN
            rdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            asid_q   <= asid_d;
            page_q   <= page_d;
            ppn_q    <= ppn_d;
            wx_q     <= wx_d;
            rem_q    <= rem_d;
            to_cnt_q <= to_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            err_pg_q <= err_pg_d;
`ifdef MMU_LOADER_VERIFY_EN
            rdata_q  <= rdata_d;
`endif
        end
    end

    assign m.cs     = in_bus;
    assign m.cyc    = in_bus;
    assign m.stb    = in_bus;
    assign m.we     = (state_q == StWr);
    assign m.asid   = asid_q;
    // Address is forced to zero outside a run so an idle loader presents an all-zero bus.
    assign m.adr    = busy_q ? {CFG_BASE[31:11], page_q, 2'b00} : 32'h0;
    assign m.dat_o  = {14'h0, wx_q, ppn_q};
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign err_pg_o = err_pg_q;

endmodule

// File: tb/tb_rf68000_mmu_loader.sv
// Randomized self-checking bench for rf68000_mmu_loader with an MMU slave model and
// an arithmetic reference for the expected write list, latency and error reporting.
module tb_rf68000_mmu_loader;

    localparam int unsigned ToCycles = 64;
    localparam logic [31:0] CfgBase  = 32'hFDC00000;
    localparam int          Bound    = 20000;
`ifdef MMU_LOADER_VERIFY_EN
    localparam int          PerEntry = 8;
`else
    localparam int          PerEntry = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  asid_i;
    logic [8:0]  first_pg_i;
    logic [9:0]  count_i;
    logic [15:0] base_ppn_i;
    logic [1:0]  wx_i;
    logic        busy_o, done_o, err_o;
    logic [8:0]  err_pg_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rf68000_mmu_loader_if bus ();

    rf68000_mmu_loader #(
        .CFG_BASE  (CfgBase),
        .TO_CYCLES (ToCycles)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .asid_i     (asid_i),
        .first_pg_i (first_pg_i),
        .count_i    (count_i),
        .base_ppn_i (base_ppn_i),
        .wx_i       (wx_i),
        .m          (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_pg_o   (err_pg_o)
    );

    // MMU slave: write ack one cycle after strobe, read ack three cycles after strobe.
    logic        ack_en;
    logic        corrupt_en;
    logic [8:0]  corrupt_pg;
    logic [17:0] mem [512];
    int          lat_cnt;

    always @(posedge clk) begin
        if (rst_i) begin
            bus.ack   <= 1'b0;
            bus.dat_i <= 32'h0;
            lat_cnt   <= 0;
        end else if (bus.cyc && bus.stb && !bus.ack) begin
            if (bus.we) begin
                if (ack_en) begin
                    bus.ack <= 1'b1;
                    mem[bus.adr[10:2]] <= bus.dat_o[17:0];
                end
            end else if (lat_cnt == 2) begin
                lat_cnt <= 0;
                if (ack_en) begin
                    bus.ack   <= 1'b1;
                    bus.dat_i <= {14'h0, mem[bus.adr[10:2]] ^
                                 ((corrupt_en && bus.adr[10:2] == corrupt_pg) ? 18'h10000 : 18'h0)};
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            bus.ack <= 1'b0;
            if (!bus.stb) lat_cnt <= 0;
        end
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [7:0]  asid;
    } wr_t;
    wr_t wq[$];

    always @(posedge clk) begin
        if (!rst_i && bus.cyc && bus.stb && bus.we && bus.ack)
            wq.push_back('{adr: bus.adr, dat: bus.dat_o, asid: bus.asid});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        asid_i     = 8'($urandom);
        first_pg_i = 9'($urandom);
        count_i    = 10'($urandom_range(1, 20));
        base_ppn_i = 16'($urandom);
        wx_i       = 2'($urandom);
    endtask

    // One run; expected writes come from page/ppn arithmetic over the run parameters.
    task automatic do_run(input logic [7:0] asid, input logic [8:0] pg, input logic [9:0] cnt,
                          input logic [15:0] ppn, input logic [1:0] wx, input int glitch,
                          input bit exp_err, input logic [8:0] exp_errpg,
                          input int exp_writes, input int exp_lat);
        int lat;
        int extra;
        int n;
        wq.delete();
        @(negedge clk);
        asid_i = asid; first_pg_i = pg; count_i = cnt; base_ppn_i = ppn; wx_i = wx;
        start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        scramble_inputs();
        lat = 1;
        forever begin
            if (done_o || lat >= Bound) break;
            start_i = (lat == glitch);
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        check_eq("done_pulse", done_o, 1'b1);
        if (exp_lat >= 0) check_eq("latency", lat, exp_lat);
        check_eq("err", err_o, exp_err);
        check_eq("err_pg", err_pg_o, exp_errpg);
        check_eq("busy_at_done", busy_o, 1'b0);
        check_eq("strobes_at_done", {bus.cs, bus.cyc, bus.stb, bus.we}, 4'h0);
        n = wq.size();
        check_eq("n_writes", n, exp_writes);
        for (int i = 0; i < n && i < exp_writes; i++) begin
            int page;
            int p;
            page = (int'(pg) + i) % 512;
            p    = (int'(ppn) + i) % 65536;
            check_eq("wr_adr", wq[i].adr, CfgBase + 32'(page * 4));
            check_eq("wr_dat", wq[i].dat, 32'(int'(wx) * 65536 + p));
            check_eq("wr_asid", wq[i].asid, asid);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check_eq("no_extra_done", extra, 0);
    endtask

    initial begin
        logic [8:0] pg;
        logic [9:0] cnt;
        rst_i = 1'b1; start_i = 1'b0; ack_en = 1'b1; corrupt_en = 1'b0; corrupt_pg = '0;
        asid_i = '0; first_pg_i = '0; count_i = '0; base_ppn_i = '0; wx_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_strobes", {bus.cs, bus.cyc, bus.stb, bus.we}, 4'h0);
        check_eq("rst_adr", bus.adr, 32'h0);
        check_eq("rst_dat", bus.dat_o, 32'h0);
        check_eq("rst_asid", bus.asid, 8'h0);
        check_eq("rst_flags", {busy_o, done_o, err_o}, 3'b000);
        check_eq("rst_err_pg", err_pg_o, 9'h0);
        rst_i = 1'b0;

        // Basic run with a start pulse while busy.
        do_run(8'd5, 9'h010, 10'd4, 16'h1200, 2'b11, 5, 1'b0, 9'h0, 4, PerEntry * 4 + 2);
        if (wq.size() > 0) begin
            check_eq("t1_first_ofs", wq[0].adr[11:0], 12'h040);
            check_eq("t1_first_dat", wq[0].dat, 32'h31200);
        end

        // Page wrap 511->0 and ppn wrap 0xFFFF->0.
        do_run(8'($urandom), 9'h1FE, 10'd3, 16'hFFFF, 2'b01, -1, 1'b0, 9'h0, 3, PerEntry * 3 + 2);

        // Zero-length run, start pulsed in FIN.
        do_run(8'd7, 9'h055, 10'd0, 16'h0042, 2'b10, 1, 1'b0, 9'h0, 0, 2);

        // Timeout on the first write.
        ack_en = 1'b0;
        pg = 9'($urandom);
        do_run(8'd3, pg, 10'd3, 16'h0100, 2'b11, -1, 1'b1, pg, 0, ToCycles + 2);
        ack_en = 1'b1;
        // err_o/err_pg_o are cleared by the next start.
        do_run(8'd3, pg, 10'd2, 16'h0200, 2'b00, -1, 1'b0, 9'h0, 2, PerEntry * 2 + 2);

`ifdef MMU_LOADER_VERIFY_EN
        pg = 9'($urandom);
        corrupt_en = 1'b1;
        corrupt_pg = pg + 9'd1;
        do_run(8'd9, pg, 10'd4, 16'h3000, 2'b11, -1, 1'b1, pg + 9'd1, 2, PerEntry * 2 + 2);
        corrupt_en = 1'b0;
`endif

        // Reset during WR aborts the run without done_o.
        @(negedge clk);
        asid_i = 8'hA5; first_pg_i = 9'h100; count_i = 10'd5; base_ppn_i = 16'h7777; wx_i = 2'b11;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check_eq("wr_before_rst", bus.cyc, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_strobes", {bus.cs, bus.cyc, bus.stb, bus.we}, 4'h0);
        check_eq("mid_rst_adr_dat", {bus.adr, bus.dat_o}, 64'h0);
        check_eq("mid_rst_asid", bus.asid, 8'h0);
        check_eq("mid_rst_flags", {busy_o, done_o, err_o, err_pg_o}, 12'h0);
        @(negedge clk);
        rst_i = 1'b0;
        do_run(8'h11, 9'h0F0, 10'd3, 16'h0010, 2'b10, -1, 1'b0, 9'h0, 3, PerEntry * 3 + 2);

        // Maximum-length run covers the full page space.
        pg = 9'($urandom);
        do_run(8'h22, pg, 10'd512, 16'($urandom), 2'($urandom), -1, 1'b0, 9'h0, 512,
               PerEntry * 512 + 2);

        for (int k = 0; k < 12; k++) begin
            int g;
            pg  = 9'($urandom);
            cnt = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
            g   = $urandom_range(1, PerEntry * int'(cnt) + 1);
            do_run(8'($urandom), pg, cnt, 16'($urandom), 2'($urandom), g, 1'b0, 9'h0,
                   int'(cnt), PerEntry * int'(cnt) + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
